// File: rtl/tinytester_pkg.sv
// Shared constants for the phase-sequenced pin tester.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tinytester_pkg;

  // Sequencer state encoding, also visible on state_o
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE    = 2'd2;
  localparam logic [STATE_W-1:0] ST_ILLEGAL = 2'd3;

  // Supported parameter ranges
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;
  localparam int PHASES_MIN = 2;
  localparam int PHASES_MAX = 16;

endpackage

// File: rtl/tinytester_seq_if.sv
// Register-side and pad-side bundle of the pin tester.
// Latency: n/a (wires only).
// Backpressure: none; software holds config stable while busy.
interface tinytester_seq_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 8,
  parameter int REP_W      = 16
);
  localparam int PH_W = $clog2(NUM_PHASES);

  // control / config from the register block
  logic                          go_i;
  logic [WIDTH-1:0]              dataout_i;
  logic [WIDTH-1:0]              oe_i;
  logic [NUM_PHASES*WIDTH-1:0]   active_i;
  logic [NUM_PHASES*DWELL_W-1:0] dwell_i;
  logic [PH_W-1:0]               cap_phase_i;
  logic [REP_W-1:0]              repeat_i;
  logic [WIDTH-1:0]              expect_i;
  logic [WIDTH-1:0]              expect_mask_i;
  // pad ring
  logic [WIDTH-1:0]              padin_i;
  logic [WIDTH-1:0]              padout_o;
  logic [WIDTH-1:0]              padoe_o;
  // status back to the register block
  logic [WIDTH-1:0]              datain_o;
  logic                          mismatch_o;
  logic                          busy_o;
  logic                          done_o;
  logic                          aborted_o;
  logic [1:0]                    state_o;

  modport master (
    output go_i, dataout_i, oe_i, active_i, dwell_i, cap_phase_i, repeat_i,
           expect_i, expect_mask_i, padin_i,
    input  padout_o, padoe_o, datain_o, mismatch_o, busy_o, done_o,
           aborted_o, state_o
  );

  modport slave (
    input  go_i, dataout_i, oe_i, active_i, dwell_i, cap_phase_i, repeat_i,
           expect_i, expect_mask_i, padin_i,
    output padout_o, padoe_o, datain_o, mismatch_o, busy_o, done_o,
           aborted_o, state_o
  );

endinterface

// File: rtl/tinytester_phase_sel.sv
// Selects one phase's mask and dwell out of the flattened config buses.
// Latency: combinational.
// Backpressure: none.
module tinytester_phase_sel #(
  parameter int WIDTH      = 32,
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 8,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic [PH_W-1:0]               idx_i,
  input  logic [PH_W-1:0]               cap_phase_i,
  input  logic [NUM_PHASES*WIDTH-1:0]   active_i,
  input  logic [NUM_PHASES*DWELL_W-1:0] dwell_i,
  output logic [WIDTH-1:0]              mask_o,
  output logic [DWELL_W-1:0]            dwell_o,
  output logic                          cap_hit_o,
  output logic                          last_o
);

  // Explicit compare per phase so an index past NUM_PHASES-1 yields zeros
  always_comb begin
    mask_o  = '0;
    dwell_o = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (idx_i == PH_W'(p)) begin
        mask_o  = active_i[p*WIDTH +: WIDTH];
        dwell_o = dwell_i[p*DWELL_W +: DWELL_W];
      end
    end
  end

  assign cap_hit_o = (idx_i == cap_phase_i);
  assign last_o    = (idx_i == PH_W'(NUM_PHASES - 1));

endmodule

// File: rtl/tinytester_seq.sv
// Phase-sequenced pad driver with per-iteration capture and masked compare.
// Latency: phase-0 pattern on pads one edge after go_i is sampled; DONE on the edge ending the last phase.
// Backpressure: none; dropping go_i mid-run aborts on the next edge and tri-states the pads.
module tinytester_seq
  import tinytester_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_PHASES = 4,
  parameter int DWELL_W    = 8,
  parameter int REP_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  tinytester_seq_if.slave io
);

  localparam int PH_W = $clog2(NUM_PHASES);

  logic [STATE_W-1:0] state_q,     state_d;
  logic [PH_W-1:0]    phase_q,     phase_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [REP_W-1:0]   iter_cnt_q,  iter_cnt_d;
  logic [WIDTH-1:0]   padout_q,    padout_d;
  logic [WIDTH-1:0]   padoe_q,     padoe_d;
  logic [WIDTH-1:0]   datain_q,    datain_d;
  logic               mismatch_q,  mismatch_d;
  logic               aborted_q,   aborted_d;

  // current-phase decode (capture point and end of iteration)
  logic               cur_cap_hit, cur_last;
  logic [WIDTH-1:0]   cur_mask_unused;
  logic [DWELL_W-1:0] cur_dwell_unused;
  // reload source: next phase, or phase 0 at start / wrap
  logic [PH_W-1:0]    nxt_idx;
  logic [WIDTH-1:0]   nxt_mask;
  logic [DWELL_W-1:0] nxt_dwell;
  logic               nxt_cap_hit_unused, nxt_last_unused;

  tinytester_phase_sel #(
    .WIDTH(WIDTH), .NUM_PHASES(NUM_PHASES), .DWELL_W(DWELL_W), .PH_W(PH_W)
  ) u_cur_sel (
    .idx_i       (phase_q),
    .cap_phase_i (io.cap_phase_i),
    .active_i    (io.active_i),
    .dwell_i     (io.dwell_i),
    .mask_o      (cur_mask_unused),
    .dwell_o     (cur_dwell_unused),
    .cap_hit_o   (cur_cap_hit),
    .last_o      (cur_last)
  );

  // Index of the phase to load on the next phase boundary
  always_comb begin
    nxt_idx = '0;
    if (state_q == ST_RUN && !cur_last) begin
      nxt_idx = phase_q + 1'b1;
    end
  end

  tinytester_phase_sel #(
    .WIDTH(WIDTH), .NUM_PHASES(NUM_PHASES), .DWELL_W(DWELL_W), .PH_W(PH_W)
  ) u_nxt_sel (
    .idx_i       (nxt_idx),
    .cap_phase_i (io.cap_phase_i),
    .active_i    (io.active_i),
    .dwell_i     (io.dwell_i),
    .mask_o      (nxt_mask),
    .dwell_o     (nxt_dwell),
    .cap_hit_o   (nxt_cap_hit_unused),
    .last_o      (nxt_last_unused)
  );

  // Sequencer next state: phase stepping, iteration repeat, capture, abort
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dwell_cnt_d = dwell_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    padout_d    = padout_q;
    padoe_d     = padoe_q;
    datain_d    = datain_q;
    mismatch_d  = mismatch_q;
    aborted_d   = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (io.go_i) begin
          state_d     = ST_RUN;
          phase_d     = '0;
          dwell_cnt_d = nxt_dwell;
          iter_cnt_d  = io.repeat_i;
          padout_d    = io.dataout_i & nxt_mask;
          padoe_d     = io.oe_i;
          mismatch_d  = 1'b0;
          aborted_d   = 1'b0;
        end
      end

      ST_RUN: begin
        if (!io.go_i) begin
          // abort beats any phase end or capture due on this edge
          state_d   = ST_IDLE;
          padoe_d   = '0;
          aborted_d = 1'b1;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else begin
          // last cycle of the current phase
          if (cur_cap_hit) begin
            datain_d = io.padin_i;
            if (((io.padin_i ^ io.expect_i) & io.expect_mask_i) != '0) begin
              mismatch_d = 1'b1;
            end
          end
          if (!cur_last) begin
            phase_d     = phase_q + 1'b1;
            dwell_cnt_d = nxt_dwell;
            padout_d    = io.dataout_i & nxt_mask;
          end else if (iter_cnt_q != '0) begin
            iter_cnt_d  = iter_cnt_q - 1'b1;
            phase_d     = '0;
            dwell_cnt_d = nxt_dwell;
            padout_d    = io.dataout_i & nxt_mask;
          end else begin
            // pads keep driving the final pattern
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!io.go_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // unused encoding recovers to IDLE without touching the pads
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      dwell_cnt_q <= '0;
      iter_cnt_q  <= '0;
      padout_q    <= '0;
      padoe_q     <= '0;
      datain_q    <= '0;
      mismatch_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      dwell_cnt_q <= dwell_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      padout_q    <= padout_d;
      padoe_q     <= padoe_d;
      datain_q    <= datain_d;
      mismatch_q  <= mismatch_d;
      aborted_q   <= aborted_d;
    end
  end

  assign io.padout_o   = padout_q;
  assign io.padoe_o    = padoe_q;
  assign io.datain_o   = datain_q;
  assign io.mismatch_o = mismatch_q;
  assign io.aborted_o  = aborted_q;
  assign io.busy_o     = (state_q == ST_RUN);
  assign io.done_o     = (state_q == ST_DONE);
  assign io.state_o    = state_q;

endmodule

// File: tb/tb_tinytester_seq.sv
// Directed bench for tinytester_seq: vector table plus abort/reset/illegal-state sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_tinytester_seq;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tinytester_seq_if #(.WIDTH(32), .NUM_PHASES(4), .DWELL_W(8), .REP_W(16)) bus ();

  tinytester_seq #(.WIDTH(32), .NUM_PHASES(4), .DWELL_W(8), .REP_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dwell;     // phase p dwell at [p*8 +: 8]
    logic [15:0] rep;
    logic [1:0]  cap;
    logic [31:0] expv;
    logic [31:0] emask;
    logic [31:0] padin;
    bit          vary;      // drive a distinct padin every cycle
    bit          exp_mism;
    int          exp_busy;  // hand-computed (rep+1)*sum(dwell+1)
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] dataout_v;
  logic [31:0] oe_v;
  logic [127:0] masks_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] expq[$];
    logic [31:0] prev;
    int idx, last_cap, ncaps, ncyc, nchg;
    bus.dwell_i       = v.dwell;
    bus.repeat_i      = v.rep;
    bus.cap_phase_i   = v.cap;
    bus.expect_i      = v.expv;
    bus.expect_mask_i = v.emask;
    bus.padin_i       = v.padin;
    idx = 0; last_cap = 0; ncaps = 0;
    for (int it = 0; it <= int'(v.rep); it++) begin
      for (int p = 0; p < 4; p++) begin
        for (int d = 0; d <= int'(v.dwell[p*8 +: 8]); d++) begin
          expq.push_back(dataout_v & masks_v[p*32 +: 32]);
          if (p == int'(v.cap) && d == int'(v.dwell[p*8 +: 8])) begin
            last_cap = idx;
            ncaps++;
          end
          idx++;
        end
      end
    end
    prev = bus.datain_o;
    bus.go_i = 1'b1;
    tick();
    check($sformatf("v%0d busy at start", id), 32'(bus.busy_o), 32'd1);
    check($sformatf("v%0d mismatch cleared", id), 32'(bus.mismatch_o), 32'd0);
    check($sformatf("v%0d aborted cleared", id), 32'(bus.aborted_o), 32'd0);
    check($sformatf("v%0d padoe", id), bus.padoe_o, oe_v);
    ncyc = 0; nchg = 0;
    while (bus.busy_o && ncyc < 2000) begin
      if (ncyc < expq.size()) check($sformatf("v%0d padout c%0d", id, ncyc), bus.padout_o, expq[ncyc]);
      if (v.vary) bus.padin_i = 32'h100 + ncyc;
      tick();
      ncyc++;
      if (bus.datain_o !== prev) nchg++;
      prev = bus.datain_o;
    end
    check($sformatf("v%0d busy cycles", id), ncyc, v.exp_busy);
    check($sformatf("v%0d state done", id), 32'(bus.state_o), 32'd2);
    check($sformatf("v%0d done_o", id), 32'(bus.done_o), 32'd1);
    check($sformatf("v%0d mismatch", id), 32'(bus.mismatch_o), 32'(v.exp_mism));
    if (v.vary) begin
      check($sformatf("v%0d datain", id), bus.datain_o, 32'h100 + last_cap);
      check($sformatf("v%0d captures", id), nchg, ncaps);
    end else begin
      check($sformatf("v%0d datain", id), bus.datain_o, v.padin);
    end
    check($sformatf("v%0d padout held", id), bus.padout_o, dataout_v & masks_v[96 +: 32]);
    bus.go_i = 1'b0;
    tick();
    check($sformatf("v%0d idle after go low", id), 32'(bus.state_o), 32'd0);
    check($sformatf("v%0d done cleared", id), 32'(bus.done_o), 32'd0);
    check($sformatf("v%0d padoe still driven", id), bus.padoe_o, oe_v);
  endtask

  initial begin
    logic [31:0] prev_datain;
    logic [31:0] prev_padout;
    logic [31:0] prev_padoe;
    int done_seen;
    n_tests = 0;
    n_fail  = 0;
    dataout_v = 32'hFFFF_FFFF;
    oe_v      = 32'hFFFF_00FF;
    masks_v   = {32'h8, 32'h4, 32'h2, 32'h1};

    vecs[0] = '{dwell:32'h0000_0000, rep:16'd0, cap:2'd3, expv:32'h0, emask:32'h0,
                padin:32'hA5A5_A5A5, vary:1'b0, exp_mism:1'b0, exp_busy:4};
    vecs[1] = '{dwell:32'h0000_0000, rep:16'd0, cap:2'd3, expv:32'h1234_5678, emask:32'h0000_FFFF,
                padin:32'h1234_0000, vary:1'b0, exp_mism:1'b1, exp_busy:4};
    vecs[2] = '{dwell:32'h0000_0000, rep:16'd0, cap:2'd3, expv:32'h1234_5678, emask:32'hFFFF_0000,
                padin:32'h1234_0000, vary:1'b0, exp_mism:1'b0, exp_busy:4};
    vecs[3] = '{dwell:32'h0001_0002, rep:16'd2, cap:2'd3, expv:32'h0, emask:32'h0,
                padin:32'h0, vary:1'b1, exp_mism:1'b0, exp_busy:21};
    vecs[4] = '{dwell:32'h0101_0101, rep:16'd1, cap:2'd2, expv:32'h0000_0F0E, emask:32'h0000_0001,
                padin:32'h0000_0F0F, vary:1'b0, exp_mism:1'b1, exp_busy:16};
    vecs[5] = '{dwell:32'h0000_00FF, rep:16'd0, cap:2'd1, expv:32'h5, emask:32'hFFFF,
                padin:32'h5, vary:1'b0, exp_mism:1'b0, exp_busy:259};
    vecs[6] = '{dwell:32'h0300_0000, rep:16'd3, cap:2'd0, expv:32'h0, emask:32'h0,
                padin:32'h0, vary:1'b1, exp_mism:1'b0, exp_busy:28};

    rst_n = 1'b0;
    bus.go_i = 1'b0;
    bus.dataout_i = dataout_v;
    bus.oe_i = oe_v;
    bus.active_i = masks_v;
    bus.dwell_i = '0;
    bus.cap_phase_i = '0;
    bus.repeat_i = '0;
    bus.expect_i = '0;
    bus.expect_mask_i = '0;
    bus.padin_i = '0;
    repeat (2) tick();
    check("reset state", 32'(bus.state_o), 32'd0);
    check("reset padout", bus.padout_o, 32'd0);
    check("reset padoe", bus.padoe_o, 32'd0);
    check("reset datain", bus.datain_o, 32'd0);
    check("reset mismatch", 32'(bus.mismatch_o), 32'd0);
    check("reset aborted", 32'(bus.aborted_o), 32'd0);
    check("reset busy", 32'(bus.busy_o), 32'd0);
    check("reset done", 32'(bus.done_o), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // abort in the 2nd cycle of a dwell-5 phase
    bus.dwell_i = 32'h0000_0005;
    bus.cap_phase_i = 2'd0;
    bus.repeat_i = 16'd0;
    bus.go_i = 1'b1;
    tick();
    check("abort busy", 32'(bus.busy_o), 32'd1);
    tick();
    bus.go_i = 1'b0;
    tick();
    check("abort state", 32'(bus.state_o), 32'd0);
    check("abort padoe", bus.padoe_o, 32'd0);
    check("abort aborted", 32'(bus.aborted_o), 32'd1);
    check("abort padout held", bus.padout_o, 32'h1);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done_o) done_seen++;
      tick();
    end
    check("abort done never", done_seen, 0);
    check("abort sticky", 32'(bus.aborted_o), 32'd1);

    // go low on the edge that ends the final capture phase: abort wins, no capture
    bus.dwell_i = 32'h0;
    bus.cap_phase_i = 2'd3;
    bus.padin_i = 32'h1111_1111;
    prev_datain = bus.datain_o;
    bus.go_i = 1'b1;
    repeat (4) tick();
    check("late abort in phase 3", bus.padout_o, 32'h8);
    bus.padin_i = 32'h2222_2222;
    bus.go_i = 1'b0;
    tick();
    check("late abort state", 32'(bus.state_o), 32'd0);
    check("late abort aborted", 32'(bus.aborted_o), 32'd1);
    check("late abort done", 32'(bus.done_o), 32'd0);
    check("late abort no capture", bus.datain_o, prev_datain);

    // synchronous reset mid-run
    bus.dwell_i = 32'h0303_0303;
    bus.go_i = 1'b1;
    repeat (3) tick();
    check("pre-reset busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    bus.go_i = 1'b0;
    tick();
    check("midrun reset state", 32'(bus.state_o), 32'd0);
    check("midrun reset padout", bus.padout_o, 32'd0);
    check("midrun reset padoe", bus.padoe_o, 32'd0);
    check("midrun reset datain", bus.datain_o, 32'd0);
    check("midrun reset aborted", 32'(bus.aborted_o), 32'd0);
    rst_n = 1'b1;
    tick();
    run_vec(10, vecs[1]);

    // unused state encoding recovers to IDLE with outputs untouched
    prev_padout = bus.padout_o;
    prev_padoe  = bus.padoe_o;
    prev_datain = bus.datain_o;
    @(negedge clk);
    force dut.state_q = 2'd3;
    #1;
    check("illegal state visible", 32'(bus.state_o), 32'd3);
    #1;
    release dut.state_q;
    tick();
    check("illegal to idle", 32'(bus.state_o), 32'd0);
    check("illegal padout", bus.padout_o, prev_padout);
    check("illegal padoe", bus.padoe_o, prev_padoe);
    check("illegal datain", bus.datain_o, prev_datain);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
